// File: rtl/mat_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mat_mul_pkg
//  Description : Shared definitions for the matrix-multiply accelerator.
//                Holds the IDLE/STREAM/DONE state encoding used by the
//                sequencing stages and a constant-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mat_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } mm_state_t;

    // Number of bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_result_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mat_result_streamer_if
//  Description : Control, result-BRAM read port and AXI-Stream master bundle
//                of the result streamer.
//                master : streamer side (drives busy/done, rd_*, m00_axis_*)
//                slave  : system side (drives start, rd_data, tready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mat_result_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_LOG   = 2
);
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      rd_en;
    logic [SIZE_LOG-1:0]       rd_addr;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      m00_axis_tvalid;
    logic [DATA_WIDTH-1:0]     m00_axis_tdata;
    logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb;
    logic                      m00_axis_tlast;
    logic                      m00_axis_tready;

    modport master (
        input  start,
        output busy,
        output done,
        output rd_en,
        output rd_addr,
        input  rd_data,
        output m00_axis_tvalid,
        output m00_axis_tdata,
        output m00_axis_tstrb,
        output m00_axis_tlast,
        input  m00_axis_tready
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  m00_axis_tvalid,
        input  m00_axis_tdata,
        input  m00_axis_tstrb,
        input  m00_axis_tlast,
        output m00_axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/mat_result_streamer_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_fifo
//  Description : Two-entry push/pop FIFO with occupancy output. The head entry
//                is presented combinationally on o_head.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_push/i_data- write strobe and data
//                i_pop        - remove head entry
//                o_head       - current head entry (zero after reset)
//                o_occ        - number of stored entries (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Push and pop together leave occupancy unchanged; with one
            // entry stored the write lands in the slot the read pointer
            // moves to, so the new head is the freshly pushed word.
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(i_push && (r_occ == 2'd2)));

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_occ == 2'd0)));

endmodule
`default_nettype wire

// File: rtl/mat_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : mat_result_streamer
//  Description : Reads the SIZE-word result BRAM in row-major order (1-cycle
//                read latency) and emits it as one AXI-Stream packet with
//                full backpressure, tlast on the final word.
//  Ports       : s00_axi_aclk   - clock, rising edge
//                s00_axi_areset - synchronous active-high reset
//                bus (master)   - start/busy/done, rd_en/rd_addr/rd_data,
//                                 m00_axis_tvalid/tdata/tstrb/tlast/tready
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_result_streamer
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG    = 1,
    parameter int DIM        = 2 ** DIM_LOG,
    parameter int SIZE       = DIM * DIM,
    parameter int SIZE_LOG   = 2 * DIM_LOG,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_areset,
    mat_result_streamer_if.master bus
);

    // The issue counter must reach SIZE itself, one more than an address.
    localparam int                    c_CNT_W     = clog2(SIZE + 1);
    localparam logic [c_CNT_W-1:0]    c_SIZE      = c_CNT_W'(SIZE);
    localparam logic [SIZE_LOG-1:0]   c_LAST_BEAT = SIZE_LOG'(SIZE - 1);

    mm_state_t             r_state;
    mm_state_t             w_state_next;
    logic [c_CNT_W-1:0]    r_issued;
    logic [SIZE_LOG-1:0]   r_beat;
    logic [SIZE_LOG-1:0]   r_addr_hold;
    logic                  r_inflight;

    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_tvalid;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic                  w_last_beat;
    logic                  w_rd_en;
    logic                  w_clear;
    logic                  w_busy;
    logic                  w_done;

    assign w_tvalid    = (w_occ != 2'd0);
    assign w_pop       = w_tvalid && bus.m00_axis_tready;
    assign w_last_beat = (r_beat == c_LAST_BEAT);

    // A new read is allowed only if, after this cycle's pop, buffered words
    // plus the read still in flight leave room for it in the 2-entry FIFO.
    assign w_credit_ok = (({1'b0, w_occ} + {2'b00, r_inflight}) <=
                          (3'd1 + {2'b00, w_pop}));

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_clear      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_busy  = 1'b1;
                w_rd_en = (r_issued < c_SIZE) && w_credit_ok;
                if (w_pop && w_last_beat) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_issued    <= '0;
            r_beat      <= '0;
            r_addr_hold <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_clear) begin
                r_issued <= '0;
                r_beat   <= '0;
            end else begin
                if (w_rd_en) begin
                    r_issued    <= r_issued + c_CNT_W'(1);
                    r_addr_hold <= r_issued[SIZE_LOG-1:0];
                end
                if (w_pop) begin
                    r_beat <= r_beat + SIZE_LOG'(1);
                end
            end
        end
    end

    // Read data returns one cycle after rd_en and is pushed straight in.
    stream_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_fifo (
        .clk    (s00_axi_aclk),
        .rst    (s00_axi_areset),
        .i_push (r_inflight),
        .i_data (bus.rd_data),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    assign bus.busy            = w_busy;
    assign bus.done            = w_done;
    assign bus.rd_en           = w_rd_en;
    assign bus.rd_addr         = w_rd_en ? r_issued[SIZE_LOG-1:0] : r_addr_hold;
    assign bus.m00_axis_tvalid = w_tvalid;
    assign bus.m00_axis_tdata  = w_head;
    assign bus.m00_axis_tstrb  = '1;
    assign bus.m00_axis_tlast  = w_last_beat && w_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_mat_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_result_streamer
//  Description : Self-checking bench for mat_result_streamer. Two instances:
//                A with DIM_LOG=1 (4 words) and B with DIM_LOG=2 (16 words),
//                each fed from a behavioural 1-cycle-latency BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_result_streamer;

    localparam int SIZE_A = 4;
    localparam int SIZE_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mat_result_streamer_if #(.DATA_WIDTH(32), .SIZE_LOG(2)) bus_a ();
    mat_result_streamer_if #(.DATA_WIDTH(32), .SIZE_LOG(4)) bus_b ();

    mat_result_streamer #(.DIM_LOG(1), .DATA_WIDTH(32)) dut_a (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst_a),
        .bus            (bus_a)
    );

    mat_result_streamer #(.DIM_LOG(2), .DATA_WIDTH(32)) dut_b (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst_b),
        .bus            (bus_b)
    );

    // Result BRAMs: read data valid the cycle after rd_en.
    logic [31:0] mem_a [SIZE_A];
    logic [31:0] mem_b [SIZE_B];

    always @(posedge clk) begin
        if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr];
        if (bus_b.rd_en) bus_b.rd_data <= mem_b[bus_b.rd_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic        st;
        logic        rs;
        logic        rdy;
        int          chk;   // 0 skip, 1 check, 2 also check tdata while idle
        logic        busy;
        logic        done;
        logic        rden;
        logic [1:0]  addr;
        logic        tv;
        logic [31:0] td;
        logic        tl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic rs, input logic rdy, input int chk,
                       input logic busy, input logic done, input logic rden, input int addr,
                       input logic tv, input int td, input logic tl);
        vec_t v;
        v.st = st; v.rs = rs; v.rdy = rdy; v.chk = chk;
        v.busy = busy; v.done = done; v.rden = rden; v.addr = 2'(addr);
        v.tv = tv; v.td = 32'(td); v.tl = tl;
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------ reference model
    // Packet = BRAM contents in address order, captured when start is taken.
    int          m_active   [2];
    int          m_beats    [2];
    int          m_reads    [2];
    int          m_pend_done[2];
    int          m_strict   [2];
    int          m_tstart   [2];
    int          m_size     [2];
    int          m_pkts     [2];
    logic        m_stall    [2];
    logic [31:0] m_pdata    [2];
    logic        m_plast    [2];
    logic [31:0] ref_pkt    [2][16];
    int          cyc = 0;

    task automatic monitor(input int id, input logic start, input logic busy, input logic done,
                           input logic rd_en, input int rd_addr, input logic tvalid,
                           input logic [31:0] tdata, input logic tlast, input logic strb_ok,
                           input logic tready);
        string nm;
        int    was_pd;
        nm     = (id == 0) ? "A" : "B";
        was_pd = m_pend_done[id];

        check({nm, ".busy"}, 32'(busy), 32'((m_active[id] != 0) && (was_pd == 0)));
        check({nm, ".done"}, 32'(done), 32'(was_pd != 0));
        if (m_stall[id]) begin
            check({nm, ".hold_tvalid"}, 32'(tvalid), 32'd1);
            check({nm, ".hold_tdata"}, tdata, m_pdata[id]);
            check({nm, ".hold_tlast"}, 32'(tlast), 32'(m_plast[id]));
        end
        if (m_active[id] == 0 || was_pd != 0) begin
            check({nm, ".quiet"}, 32'({tvalid, rd_en}), 32'd0);
        end else begin
            if (rd_en) begin
                check({nm, ".rd_addr"}, 32'(rd_addr), 32'(m_reads[id]));
                check({nm, ".rd_overrun"}, 32'(m_reads[id] < m_size[id]), 32'd1);
                m_reads[id]++;
            end
            if (tvalid) begin
                check({nm, ".tdata"}, tdata, ref_pkt[id][m_beats[id]]);
                check({nm, ".tlast"}, 32'(tlast), 32'(m_beats[id] == m_size[id] - 1));
                check({nm, ".tstrb"}, 32'(strb_ok), 32'd1);
                if (m_strict[id] != 0)
                    check({nm, ".latency"}, 32'(cyc - m_tstart[id]), 32'(3 + m_beats[id]));
            end
            if (tvalid && tready) begin
                m_beats[id]++;
                if (m_beats[id] == m_size[id]) m_pend_done[id] = 1;
            end
            check({nm, ".outstanding"}, 32'((m_reads[id] - m_beats[id]) <= 2), 32'd1);
        end
        m_stall[id] = tvalid && !tready;
        m_pdata[id] = tdata;
        m_plast[id] = tlast;

        if (was_pd != 0) begin
            check({nm, ".beats_at_done"}, 32'(m_beats[id]), 32'(m_size[id]));
            m_active[id]    = 0;
            m_pend_done[id] = 0;
            m_pkts[id]++;
        end else if (start && m_active[id] == 0) begin
            m_active[id] = 1;
            m_reads[id]  = 0;
            m_beats[id]  = 0;
            m_tstart[id] = cyc;
            for (int i = 0; i < m_size[id]; i++) begin
                if (id == 0) ref_pkt[id][i] = mem_a[i];
                else         ref_pkt[id][i] = mem_b[i];
            end
        end
    endtask

    task automatic mon_both();
        @(negedge clk);
        monitor(0, bus_a.start, bus_a.busy, bus_a.done, bus_a.rd_en, int'(bus_a.rd_addr),
                bus_a.m00_axis_tvalid, bus_a.m00_axis_tdata, bus_a.m00_axis_tlast,
                bus_a.m00_axis_tstrb == 4'hF, bus_a.m00_axis_tready);
        monitor(1, bus_b.start, bus_b.busy, bus_b.done, bus_b.rd_en, int'(bus_b.rd_addr),
                bus_b.m00_axis_tvalid, bus_b.m00_axis_tdata, bus_b.m00_axis_tlast,
                bus_b.m00_axis_tstrb == 4'hF, bus_b.m00_axis_tready);
        cyc++;
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_beats[i] = 0; m_reads[i] = 0; m_pend_done[i] = 0;
            m_strict[i] = 0; m_tstart[i] = 0; m_pkts[i] = 0;
            m_stall[i] = 1'b0; m_pdata[i] = '0; m_plast[i] = 1'b0;
        end
        m_size[0] = SIZE_A;
        m_size[1] = SIZE_B;
        mem_a[0] = 32'd5; mem_a[1] = 32'd6; mem_a[2] = 32'd7; mem_a[3] = 32'd8;
        for (int i = 0; i < SIZE_B; i++) mem_b[i] = 32'(i + 100);

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.start = 1'b0; bus_a.m00_axis_tready = 1'b1;
        bus_b.start = 1'b0; bus_b.m00_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;

        // Full-rate packet, re-start ignored in t4, one done.
        add(1,0,1,2, 0,0,0,0, 0,0,0);
        add(0,0,1,1, 1,0,1,0, 0,0,0);
        add(0,0,1,1, 1,0,1,1, 0,0,0);
        add(0,0,1,1, 1,0,1,2, 1,5,0);
        add(1,0,1,1, 1,0,1,3, 1,6,0);
        add(0,0,1,1, 1,0,0,3, 1,7,0);
        add(0,0,1,1, 1,0,0,3, 1,8,1);
        add(0,0,1,1, 0,1,0,3, 0,0,0);
        add(0,0,1,1, 0,0,0,3, 0,0,0);
        add(0,0,1,1, 0,0,0,3, 0,0,0);
        // Backpressure t3..t6: only two reads outstanding, word 5 held.
        add(1,0,1,1, 0,0,0,3, 0,0,0);
        add(0,0,1,1, 1,0,1,0, 0,0,0);
        add(0,0,1,1, 1,0,1,1, 0,0,0);
        add(0,0,0,1, 1,0,0,1, 1,5,0);
        add(0,0,0,1, 1,0,0,1, 1,5,0);
        add(0,0,0,1, 1,0,0,1, 1,5,0);
        add(0,0,0,1, 1,0,0,1, 1,5,0);
        add(0,0,1,1, 1,0,1,2, 1,5,0);
        add(0,0,1,1, 1,0,1,3, 1,6,0);
        add(0,0,1,1, 1,0,0,3, 1,7,0);
        add(0,0,1,1, 1,0,0,3, 1,8,1);
        add(0,0,1,1, 0,1,0,3, 0,0,0);
        // Reset in t5 mid-packet, then a fresh packet from address 0.
        add(1,0,1,1, 0,0,0,3, 0,0,0);
        add(0,0,1,1, 1,0,1,0, 0,0,0);
        add(0,0,1,1, 1,0,1,1, 0,0,0);
        add(0,0,1,1, 1,0,1,2, 1,5,0);
        add(0,0,1,1, 1,0,1,3, 1,6,0);
        add(0,1,1,0, 0,0,0,0, 0,0,0);
        add(1,0,1,2, 0,0,0,0, 0,0,0);
        add(0,0,1,1, 1,0,1,0, 0,0,0);
        add(0,0,1,1, 1,0,1,1, 0,0,0);
        add(0,0,1,1, 1,0,1,2, 1,5,0);
        add(0,0,1,1, 1,0,1,3, 1,6,0);
        add(0,0,1,1, 1,0,0,3, 1,7,0);
        add(0,0,1,1, 1,0,0,3, 1,8,1);
        add(0,0,1,1, 0,1,0,3, 0,0,0);
        add(0,0,1,1, 0,0,0,3, 0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_a                 = vecs[i].rs;
            bus_a.start           = vecs[i].st;
            bus_a.m00_axis_tready = vecs[i].rdy;
            @(negedge clk);
            if (vecs[i].chk != 0) begin
                check($sformatf("vec%0d.busy", i),   32'(bus_a.busy),            32'(vecs[i].busy));
                check($sformatf("vec%0d.done", i),   32'(bus_a.done),            32'(vecs[i].done));
                check($sformatf("vec%0d.rd_en", i),  32'(bus_a.rd_en),           32'(vecs[i].rden));
                check($sformatf("vec%0d.rd_addr", i),32'(bus_a.rd_addr),         32'(vecs[i].addr));
                check($sformatf("vec%0d.tvalid", i), 32'(bus_a.m00_axis_tvalid), 32'(vecs[i].tv));
                check($sformatf("vec%0d.tlast", i),  32'(bus_a.m00_axis_tlast),  32'(vecs[i].tl));
                check($sformatf("vec%0d.tstrb", i),  32'(bus_a.m00_axis_tstrb),  32'hF);
                if (vecs[i].tv || vecs[i].chk == 2)
                    check($sformatf("vec%0d.tdata", i), bus_a.m00_axis_tdata, vecs[i].td);
            end
        end

        // A: tready toggling 1,0,1,0 from t3. B: 16 beats back-to-back.
        m_strict[1] = 1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            bus_a.start           = (k == 0);
            bus_b.start           = (k == 0);
            bus_a.m00_axis_tready = (k < 3) ? 1'b1 : (((k - 3) % 2) == 0);
            bus_b.m00_axis_tready = 1'b1;
            mon_both();
        end
        m_strict[1] = 0;
        check("toggle_pkts_A", 32'(m_pkts[0]), 32'd1);
        check("dim4_pkts_B", 32'(m_pkts[1]), 32'd1);

        // Randomised traffic: random data, starts (some while busy), tready modes.
        for (int c = 0; c < 3000; c++) begin
            int mode;
            @(posedge clk);
            #1;
            mode = (c / 64) % 4;
            case (mode)
                0:       begin bus_a.m00_axis_tready = 1'b1; bus_b.m00_axis_tready = 1'b1; end
                1:       begin bus_a.m00_axis_tready = 1'($urandom_range(0, 1));
                               bus_b.m00_axis_tready = 1'($urandom_range(0, 1)); end
                2:       begin bus_a.m00_axis_tready = ($urandom_range(0, 4) == 0);
                               bus_b.m00_axis_tready = ($urandom_range(0, 4) == 0); end
                default: begin bus_a.m00_axis_tready = ((c % 2) == 0);
                               bus_b.m00_axis_tready = ((c % 2) == 1); end
            endcase
            bus_a.start = 1'b0;
            bus_b.start = 1'b0;
            if (m_active[0] == 0 && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < SIZE_A; i++) mem_a[i] = $urandom;
                bus_a.start = 1'b1;
            end else if (m_active[0] != 0 && $urandom_range(0, 15) == 0) begin
                bus_a.start = 1'b1;
            end
            if (m_active[1] == 0 && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < SIZE_B; i++) mem_b[i] = $urandom;
                bus_b.start = 1'b1;
            end else if (m_active[1] != 0 && $urandom_range(0, 15) == 0) begin
                bus_b.start = 1'b1;
            end
            mon_both();
        end

        // Drain with tready high; bounded.
        begin
            int budget;
            budget = 0;
            while ((m_active[0] != 0 || m_active[1] != 0) && budget < 300) begin
                @(posedge clk);
                #1;
                bus_a.start = 1'b0; bus_b.start = 1'b0;
                bus_a.m00_axis_tready = 1'b1; bus_b.m00_axis_tready = 1'b1;
                mon_both();
                budget++;
            end
            check("drain_idle", 32'(m_active[0] + m_active[1]), 32'd0);
        end
        check("random_pkts_A", 32'(m_pkts[0] > 20), 32'd1);
        check("random_pkts_B", 32'(m_pkts[1] > 10), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mat_result_streamer.md
# mat_result_streamer

Downstream output stage of the matrix-multiply accelerator. After the compute stage has filled the result BRAM (R), this block reads all SIZE words in row-major order through the BRAM read port (1-cycle read latency). It emits them as one AXI-Stream master packet with full backpressure support and asserts `tlast` on the final word. It replaces ad-hoc output sequencing and owns the `m00_axis_*` port of `mat_mul`.

## Interface
- `DIM_LOG`, default 1: log2 of the matrix dimension.
- `DIM`, default 2**DIM_LOG: matrix dimension.
- `SIZE`, default DIM*DIM: words per packet.
- `SIZE_LOG`, default 2*DIM_LOG: address width.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.

Ports:
- `s00_axi_aclk`  in  1  sole clock, rising edge.
- `s00_axi_areset`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request to stream R; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last beat handshakes.
- `rd_en`  out  1  R BRAM read enable.
- `rd_addr`  out  SIZE_LOG  R BRAM read address.
- `rd_data`  in  DATA_WIDTH  R BRAM read data, valid the cycle after `rd_en`.
- `m00_axis_tvalid`  out  1  stream valid.
- `m00_axis_tdata`  out  DATA_WIDTH  stream data.
- `m00_axis_tstrb`  out  DATA_WIDTH/8  stream byte strobes; all ones whenever `tvalid` is high.
- `m00_axis_tlast`  out  1  high only on beat SIZE-1.
- `m00_axis_tready`  in  1  downstream ready.

## Operation
- States:
  - IDLE: `start`=1 clears the counters and moves to STREAM. `start` is ignored in every other state.
  - STREAM: issues reads and emits beats. Moves to DONE on the handshake of beat SIZE-1.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Read issue:
  - `rd_en`=1 in a STREAM cycle when `issued` < SIZE and (`occ` + `inflight` − `pop`) ≤ 1.
  - `occ` is the buffer occupancy (0..2). `inflight` is the read issued last cycle (0/1). `pop` is tvalid&&tready this cycle.
  - `rd_addr` = `issued`. `issued` increments on each read.
  - `rd_addr` holds its last value when `rd_en`=0. It never exceeds SIZE-1 (no wrap).
- Buffer:
  - 2-entry FIFO; `rd_data` is pushed the cycle after `rd_en`.
  - The head drives `tdata`. `tvalid` = (`occ` ≠ 0).
  - The credit rule guarantees a push never hits a full buffer. Reaching that condition is an assertion failure.
- A beat counter increments on each handshake. `tlast` = (beat counter == SIZE-1) && `tvalid`.
- AXIS rules:
  - Once `tvalid` rises, `tvalid`, `tdata` and `tlast` hold until the handshake.
  - `tvalid` never depends combinationally on `tready`.
- Reset values:
  - `busy`, `done`, `rd_en`, `tvalid` and `tlast` are 0.
  - `rd_addr`, `tdata` and all counters are 0.
  - `tstrb` is all ones. The buffer is empty and the state is IDLE.
- Reset mid-packet aborts immediately: the next cycle shows reset values. No further `tlast` and no `done` are produced.
- Simultaneous push and pop with `occ`=1 leaves `occ`=1, and the head advances correctly.

## Timing
- `start` high in cycle t0 gives:
  - `busy`=1 and `rd_en`=1 with `rd_addr`=0 in t1;
  - `rd_data` pushed at the end of t2;
  - `tvalid`=1 in t3. Start-to-first-beat latency is 3 cycles.
- With `tready` held high: one beat per cycle. Beat k appears in cycle t3+k, and `tlast` is in t3+SIZE-1.
- `done` pulses 1 cycle after the last handshake. `busy` falls in the same cycle `done` pulses.
- Under backpressure, at most 2 reads are outstanding in total (buffered plus in flight). Full throughput resumes the cycle after `tready` returns.

## Structure
- Shared package `mat_mul_pkg`: state encoding (IDLE/STREAM/DONE) and the `clog2` width helper. `mat_mul` and its compute stage reuse both.
- Sub-module: `stream_skid_fifo`, a 2-entry push/pop FIFO with `occ` output, parameterised on DATA_WIDTH. The top level holds the FSM, counters and credit logic.

## Test plan
- DIM_LOG=1, R={5,6,7,8}, `tready`=1, `start` in t0: `rd_addr` 0,1,2,3 in t1..t4; `tdata` 5,6,7,8 in t3..t6; `tlast` only in t6; `done` in t7.
- Same data, `tready`=0 during t3..t6: `tdata`=5 and `tvalid` held, no more than 2 reads issued; after `tready` rises, beats 5,6,7,8 on consecutive cycles.
- `tready` toggling 1,0,1,0 from t3: every word is delivered exactly once, in order, and `tlast` is on word 8 only.
- `start` pulsed again in t4 during STREAM: ignored; exactly 4 beats and one `done`.
- Reset asserted in t5 mid-packet: t6 shows `tvalid`=0, `busy`=0, `rd_en`=0. A new `start` then streams a full 4-beat packet from address 0.
- DIM_LOG=2, R[i]=i+100: 16 beats 100..115 back-to-back, `tlast` on 115 only, `rd_addr` never exceeds 15.
